mem_port_arbiter: RTL

- Shares the core's single unified instruction/data memory port between two requesters.
  - Port 0: the multicycle CPU (its fetch and load/store traffic).
  - Port 1: an auxiliary master (program loader / debug DMA).
- Serialises requests, sequences the synchronous memory's read latency, and returns a one-cycle ack with registered read data.
- Sits between the CPU address/data mux and the memory macro.

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Request/ack bundle for the two requester ports plus the
//                synchronous memory port served by mem_port_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int c_STRB_W = DATA_WIDTH / 8;

    // port 0 : CPU
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [c_STRB_W-1:0]   cpu_wstrb;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    // port 1 : auxiliary master
    logic                  aux_req;
    logic                  aux_we;
    logic [ADDR_WIDTH-1:0] aux_addr;
    logic [DATA_WIDTH-1:0] aux_wdata;
    logic [c_STRB_W-1:0]   aux_wstrb;
    logic                  aux_ack;
    logic [DATA_WIDTH-1:0] aux_rdata;

    // memory macro side
    logic                  mem_en;
    logic [c_STRB_W-1:0]   mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  aux_req, aux_we, aux_addr, aux_wdata, aux_wstrb,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, aux_ack, aux_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output aux_req, aux_we, aux_addr, aux_wdata, aux_wstrb,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, aux_ack, aux_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-port arbiter for the unified instruction/data memory;
//                serialises CPU and aux requests and sequences read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int CPU_PRIORITY = 0
) (
    input  wire               clk,
    input  wire               resetn,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              owner
);
    localparam int         c_STRB_W   = DATA_WIDTH / 8;
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT     = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;
    localparam logic [1:0] c_LAT_INIT = 2'(READ_LATENCY - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  w_req_any;
    logic                  w_grant;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [c_STRB_W-1:0]   w_sel_wstrb;

    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_STRB_W-1:0]   r_wstrb;
    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_aux_rdata;

    // Tie-break: fixed priority to port 0, or the port that was not served last.
    always_comb begin
        w_req_any = bus.cpu_req | bus.aux_req;
        if (bus.cpu_req && bus.aux_req) begin
            w_grant = (CPU_PRIORITY != 0) ? 1'b0 : ~r_owner;
        end else begin
            w_grant = ~bus.cpu_req;
        end
    end

    always_comb begin
        if (w_grant) begin
            w_sel_we    = bus.aux_we;
            w_sel_addr  = bus.aux_addr;
            w_sel_wdata = bus.aux_wdata;
            w_sel_wstrb = bus.aux_wstrb;
        end else begin
            w_sel_we    = bus.cpu_we;
            w_sel_addr  = bus.cpu_addr;
            w_sel_wdata = bus.cpu_wdata;
            w_sel_wstrb = bus.cpu_wstrb;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_req_any) w_next_state = c_ISSUE;
            c_ISSUE: w_next_state = r_we ? c_DONE : c_WAIT;
            c_WAIT:  if (r_cnt == 2'd0) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Owner resets to 1 so that port 0 takes the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner     <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_cnt       <= 2'd0;
            r_cpu_rdata <= '0;
            r_aux_rdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req_any) begin
                        r_owner <= w_grant;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wstrb <= w_sel_wstrb;
                    end
                end
                c_ISSUE: begin
                    if (!r_we) r_cnt <= c_LAT_INIT;
                end
                c_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (r_owner) r_aux_rdata <= bus.mem_rdata;
                        else         r_cpu_rdata <= bus.mem_rdata;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory bus is quiet outside ISSUE so mem_en never stretches.
    always_comb begin
        bus.mem_en    = (r_state == c_ISSUE);
        bus.mem_we    = (r_state == c_ISSUE && r_we) ? r_wstrb : '0;
        bus.mem_addr  = (r_state == c_ISSUE) ? r_addr : '0;
        bus.mem_wdata = (r_state == c_ISSUE && r_we) ? r_wdata : '0;
        bus.cpu_ack   = (r_state == c_DONE) && !r_owner;
        bus.aux_ack   = (r_state == c_DONE) &&  r_owner;
        bus.cpu_rdata = r_cpu_rdata;
        bus.aux_rdata = r_aux_rdata;
        busy          = (r_state != c_IDLE);
        owner         = r_owner;
    end
endmodule
`default_nettype wire
